// File: rtl/m_pkg.sv
// m_pkg: shared milestone constants and the RGB pixel reader state type
package m_pkg;

    localparam logic [17:0] RGB_BASE_ADDR = 18'd146944;
    localparam int IMG_WIDTH  = 320;
    localparam int IMG_HEIGHT = 240;
    localparam int RGB_WORDS  = 115200;

    typedef enum logic [1:0] {S_RGB_IDLE, S_RGB_FETCH, S_RGB_DRAIN} RGB_RD_state;

endpackage

// File: rtl/word_fifo4.sv
// word_fifo4: 4-entry 16-bit FIFO exposing the two oldest words, pops 0..2 words per cycle
module word_fifo4 (
    input  logic        Clock,
    input  logic        resetn,
    input  logic        push,
    input  logic [15:0] wdata,
    input  logic [1:0]  pop,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [2:0]  count
);

    logic [15:0] mem [4];
    logic [1:0]  wp, rp;

    // storage, pointers and occupancy; push and pop may happen in the same cycle
    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            wp    <= 2'd0;
            rp    <= 2'd0;
            count <= 3'd0;
            for (int i = 0; i < 4; i++) mem[i] <= 16'd0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp      <= wp + 2'd1;
            end
            rp    <= rp + pop;
            count <= count + {2'b0, push} - {1'b0, pop};
        end
    end

    assign rdata0 = mem[rp];
    assign rdata1 = mem[rp + 2'd1];

endmodule

// File: rtl/rgb_pixel_reader.sv
// rgb_pixel_reader: streams a packed RGB frame from SRAM as valid/ready pixels; RGB_READER_CHECKSUM_EN adds frame_sum
module rgb_pixel_reader
    import m_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input  logic        Clock,
    input  logic        resetn,
    input  logic        startF,
    output logic        endF,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        pix_eol,
    output logic        pix_last
`ifdef RGB_READER_CHECKSUM_EN
    ,
    output logic [15:0] frame_sum
`endif
);

    localparam int WORDS = WIDTH * HEIGHT * 3 / 2;

    RGB_RD_state state, state_n;
    logic [16:0] wcnt;
    logic [8:0]  col;
    logic [7:0]  row;
    logic [7:0]  r1;
    logic        phase, v1, v2, start, issue, xfer;
    logic [1:0]  pop;
    logic [2:0]  count;
    logic [3:0]  occ;
    logic [15:0] w0, w1;

    word_fifo4 u_fifo (
        .Clock  (Clock),
        .resetn (resetn),
        .push   (v2),
        .wdata  (SRAM_read_data),
        .pop    (pop),
        .rdata0 (w0),
        .rdata1 (w1),
        .count  (count)
    );

    // occupancy counts this cycle's pop so the 2-deep read pipeline never stalls at full rate
    assign start     = state == S_RGB_IDLE && startF;
    assign pix_valid = state != S_RGB_IDLE && (phase ? count != 3'd0 : count >= 3'd2);
    assign xfer      = pix_valid && pix_ready;
    assign pop       = xfer ? (phase ? 2'd1 : 2'd2) : 2'd0;
    assign occ       = {1'b0, count} - {2'b0, pop} + {3'b0, v1} + {3'b0, v2};
    assign issue     = state == S_RGB_FETCH && occ < 4'd4;
    assign SRAM_we_n = 1'b1;
    assign pix_r     = pix_valid ? (phase ? r1 : w0[15:8]) : 8'd0;
    assign pix_g     = pix_valid ? (phase ? w0[15:8] : w0[7:0]) : 8'd0;
    assign pix_b     = pix_valid ? (phase ? w0[7:0] : w1[15:8]) : 8'd0;
    assign pix_eol   = pix_valid && col == 9'(WIDTH - 1);
    assign pix_last  = pix_eol && row == 8'(HEIGHT - 1);

    // state register
    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) state <= S_RGB_IDLE;
        else         state <= state_n;
    end

    // next state: start in IDLE, stop fetching after the last word, finish on the last pixel
    always_comb begin
        state_n = state;
        case (state)
            S_RGB_IDLE:  state_n = startF ? S_RGB_FETCH : S_RGB_IDLE;
            S_RGB_FETCH: state_n = issue && wcnt == 17'(WORDS - 1) ? S_RGB_DRAIN : S_RGB_FETCH;
            S_RGB_DRAIN: state_n = xfer && pix_last ? S_RGB_IDLE : S_RGB_DRAIN;
            default:     state_n = S_RGB_IDLE;
        endcase
    end

    // read pipeline, address/word counters, pixel phase and raster position
    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            endF         <= 1'b0;
            wcnt         <= 17'd0;
            col          <= 9'd0;
            row          <= 8'd0;
            phase        <= 1'b0;
            r1           <= 8'd0;
            SRAM_address <= RGB_BASE_ADDR;
        end else begin
            v1 <= issue;
            v2 <= v1;
            if (start) begin
                endF         <= 1'b0;
                wcnt         <= 17'd0;
                col          <= 9'd0;
                row          <= 8'd0;
                phase        <= 1'b0;
                SRAM_address <= RGB_BASE_ADDR;
            end else begin
                if (issue) begin
                    SRAM_address <= SRAM_address + 18'd1;
                    wcnt         <= wcnt + 17'd1;
                end
                if (xfer) begin
                    phase <= ~phase;
                    col   <= pix_eol ? 9'd0 : col + 9'd1;
                    if (!phase)   r1   <= w1[7:0];
                    if (pix_eol)  row  <= row + 8'd1;
                    if (pix_last) endF <= 1'b1;
                end
            end
        end
    end

`ifdef RGB_READER_CHECKSUM_EN
    // running sum of every transferred pixel's colour components
    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn)   frame_sum <= 16'd0;
        else if (start) frame_sum <= 16'd0;
        else if (xfer)  frame_sum <= frame_sum + 16'(pix_r) + 16'(pix_g) + 16'(pix_b);
    end
`endif

endmodule

// File: tb/tb_rgb_pixel_reader.sv
// tb_rgb_pixel_reader: scoreboard bench for rgb_pixel_reader on a 320x12 frame
module tb_rgb_pixel_reader;

    localparam int W     = 320;
    localparam int H     = 12;
    localparam int N     = W * H;
    localparam int WORDS = N * 3 / 2;
    localparam logic [17:0] BASE = 18'd146944;

    logic        Clock = 1'b0;
    logic        resetn = 1'b0;
    logic        startF = 1'b0;
    logic        endF;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data = 16'd0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic        pix_eol, pix_last;
`ifdef RGB_READER_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    int          ready_pct = 100;
    int          rd_cnt = 0;
    bit          mode01 = 1'b0;
    bit          mon_en = 1'b0;
    bit          stall_prev = 1'b0;
    bit          chk_end = 1'b0;
    logic [17:0] prev_addr = BASE;
    logic [17:0] a1 = BASE;
    logic [25:0] exp_q [$];
    logic [25:0] popped;
    logic [15:0] exp_sum;

    rgb_pixel_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .Clock          (Clock),
        .resetn         (resetn),
        .startF         (startF),
        .endF           (endF),
        .SRAM_address   (SRAM_address),
        .SRAM_we_n      (SRAM_we_n),
        .SRAM_read_data (SRAM_read_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_r          (pix_r),
        .pix_g          (pix_g),
        .pix_b          (pix_b),
        .pix_eol        (pix_eol),
        .pix_last       (pix_last)
`ifdef RGB_READER_CHECKSUM_EN
        ,
        .frame_sum      (frame_sum)
`endif
    );

    always #10 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] word_at(input int j);
        if (mode01) return 16'h0101;
        if (j == 0) return 16'h1122;
        if (j == 1) return 16'h3344;
        if (j == 2) return 16'h5566;
        return 16'(j * 40503 + 7) ^ 16'(j >>> 3);
    endfunction

    // SRAM: address seen in cycle k returns its word during cycle k+2
    always @(posedge Clock) begin
        a1             <= SRAM_address;
        SRAM_read_data <= word_at(int'(a1) - int'(BASE));
    end

    initial forever begin
        @(posedge Clock);
        #1 pix_ready = $urandom_range(99) < ready_pct;
    end

    // address monitor: each change must be a +1 step; counts issued reads
    initial forever begin
        @(negedge Clock);
        if (mon_en && SRAM_address != prev_addr) begin
            check("addr_step", SRAM_address, prev_addr + 18'd1);
            prev_addr = SRAM_address;
            rd_cnt++;
        end
    end

    // pixel monitor: head of queue must be presented while valid, popped on transfer
    initial forever begin
        @(negedge Clock);
        if (mon_en) begin
            if (chk_end) check("endF_rise", endF, 1);
            chk_end = 1'b0;
            if (stall_prev) check("stall_hold", pix_valid, 1);
            if (pix_valid) begin
                if (exp_q.size() == 0) check("extra_pix", 1, 0);
                else begin
                    check("pixel", {pix_r, pix_g, pix_b, pix_eol, pix_last}, exp_q[0]);
                    if (pix_ready) begin
                        check("endF_low", endF, 0);
                        popped = exp_q.pop_front();
                        chk_end = popped[0];
                    end
                end
            end
            stall_prev = pix_valid && !pix_ready;
        end else begin
            stall_prev = 1'b0;
            chk_end = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, pix_valid, 0);
        check({tag, "_rgb"}, {pix_r, pix_g, pix_b}, 0);
        check({tag, "_eol_last"}, {pix_eol, pix_last}, 0);
        check({tag, "_addr"}, SRAM_address, BASE);
        check({tag, "_we_n"}, SRAM_we_n, 1);
        check({tag, "_endF"}, endF, 0);
`ifdef RGB_READER_CHECKSUM_EN
        check({tag, "_sum"}, frame_sum, 0);
`endif
    endtask

    task automatic start_frame(input int pct);
        logic [15:0] w0, w1, w2;
        logic [7:0]  r, g, b;
        exp_q.delete();
        exp_sum = 16'd0;
        for (int p = 0; p < N; p++) begin
            w0 = word_at((p / 2) * 3);
            w1 = word_at((p / 2) * 3 + 1);
            w2 = word_at((p / 2) * 3 + 2);
            r = p % 2 ? w1[7:0]  : w0[15:8];
            g = p % 2 ? w2[15:8] : w0[7:0];
            b = p % 2 ? w2[7:0]  : w1[15:8];
            exp_q.push_back({r, g, b, p % W == W - 1, p == N - 1});
            exp_sum = exp_sum + 16'(r) + 16'(g) + 16'(b);
        end
        ready_pct = pct;
        rd_cnt = 0;
        @(negedge Clock);
        startF = 1'b1;
        @(posedge Clock);
        #1 startF = 1'b0;
        check("start_addr", SRAM_address, BASE);
        check("endF_clr", endF, 0);
        prev_addr = BASE;
        mon_en = 1'b1;
    endtask

    task automatic run_frame(input int pct, input bit pulse_fetch);
        int cyc = 0;
        int lat = -1;
        start_frame(pct);
        while (!endF && cyc < (pct == 100 ? WORDS + 100 : WORDS * 20)) begin
            @(negedge Clock);
            cyc++;
            if (lat < 0 && pix_valid) lat = cyc;
            if (pulse_fetch) startF = (cyc >= 100 && cyc < 104) || cyc == 2000;
        end
        startF = 1'b0;
        @(negedge Clock);
        check("end_reached", endF, 1);
        check("reads_issued", rd_cnt, WORDS);
        check("queue_drained", exp_q.size(), 0);
        check("valid_after_end", pix_valid, 0);
        if (pct == 100) begin
            check("first_latency_le5", lat <= 5 && lat > 0, 1);
            check("throughput", cyc <= WORDS + 8, 1);
        end
`ifdef RGB_READER_CHECKSUM_EN
        check("frame_sum", frame_sum, exp_sum);
`endif
        mon_en = 1'b0;
    endtask

    initial begin
        #25;
        check_reset_outputs("por");
        @(negedge Clock);
        resetn = 1'b1;
        repeat (3) @(negedge Clock);
        check("idle_valid", pix_valid, 0);

        run_frame(100, 1'b0);
        run_frame(30, 1'b0);

        start_frame(100);
        for (int i = 0; i < 20000 && rd_cnt < 5000; i++) @(negedge Clock);
        check("reached_word5000", rd_cnt, 5000);
        #3 mon_en = 1'b0;
        resetn = 1'b0;
        #1 check_reset_outputs("mid_rst");
        exp_q.delete();
        repeat (2) @(negedge Clock);
        check_reset_outputs("mid_rst_hold");
        resetn = 1'b1;
        repeat (2) @(negedge Clock);
        check("post_rst_idle", pix_valid, 0);
        run_frame(100, 1'b0);

        run_frame(100, 1'b1);

`ifdef RGB_READER_CHECKSUM_EN
        mode01 = 1'b1;
        run_frame(100, 1'b0);
        check("sum_0101", frame_sum, 16'(N * 3));
        mode01 = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_pixel_reader.md
RGB_PIXEL_READER -- requirements
Module: rgb_pixel_reader

Interface
REQ-001 SHALL have port Clock, input, 1 bit: 50 MHz system clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port startF, input, 1 bit: frame start request, sampled in IDLE only.
REQ-004 SHALL have port endF, output, 1 bit: frame complete, held high until next accepted startF.
REQ-005 SHALL have port SRAM_address, output, 18 bits: read address.
REQ-006 SHALL have port SRAM_we_n, output, 1 bit: write enable, constant 1.
REQ-007 SHALL have port SRAM_read_data, input, 16 bits: data, valid during cycle k+2 for an address presented in cycle k.
REQ-008 SHALL have port pix_valid, output, 1 bit: pixel available.
REQ-009 SHALL have port pix_ready, input, 1 bit: consumer accepts; transfer occurs on a cycle where pix_valid and pix_ready are both 1.
REQ-010 SHALL have ports pix_r, pix_g and pix_b, each output, 8 bits: pixel colour.
REQ-011 SHALL have port pix_eol, output, 1 bit: current pixel is column 319.
REQ-012 SHALL have port pix_last, output, 1 bit: current pixel is row 239, column 319.

Function
REQ-013 SHALL read the 320x240 RGB frame packed as 3 words per pixel pair: w0={R0,G0}, w1={B0,R1}, w2={G1,B1}, for 115200 words starting at 18'd146944.
REQ-014 SHALL use FSM states IDLE, FETCH, DRAIN:
- IDLE->FETCH on startF=1 (clears endF, word and pixel counters).
- FETCH->DRAIN after the 115200th read is issued.
- DRAIN->IDLE after the pix_last transfer; endF set the same cycle.
REQ-015 SHALL buffer read words in a 4-entry FIFO.
- Issue a read in a FETCH cycle only if FIFO occupancy plus in-flight reads < 4.
- In-flight reads are at most 2.
- The FIFO shall never overflow, whatever pix_ready does.
REQ-016 SHALL increment SRAM_address by 1 per issued read; SRAM_address holds its value when no read is issued.
REQ-017 SHALL emit even pixels (phase 0) as follows.
- pix_valid=1 when FIFO holds >=2 words.
- pix_r=w0[15:8], pix_g=w0[7:0], pix_b=w1[15:8].
- On transfer: pop both words, latch w1[7:0] as R1, set phase 1.
REQ-018 SHALL emit odd pixels (phase 1) as follows.
- pix_valid=1 when FIFO holds >=1 word.
- pix_r=R1, pix_g=w2[15:8], pix_b=w2[7:0].
- On transfer: pop 1 word, set phase 0.
REQ-019 SHALL hold pix_r, pix_g, pix_b, pix_eol and pix_last stable while pix_valid=1 and pix_ready=0.
REQ-020 SHALL keep column 0..319 and row 0..239 counters, advancing per transfer; column wraps 319->0 and increments row.
REQ-021 SHALL drive pix_valid=0 in IDLE; first-pixel latency after startF is at most 5 cycles with pix_ready=1.
REQ-022 SHALL sustain 2 pixels per 3 cycles with pix_ready held 1.
REQ-023 SHALL ignore startF in FETCH and DRAIN.
REQ-024 SHALL, when startF and the pix_last transfer coincide, complete to IDLE and ignore that startF.

Reset
REQ-025 SHALL, on resetn=0 at any time including mid-frame, asynchronously drive:
- state=IDLE, FIFO empty, in-flight=0, phase 0, counters 0;
- SRAM_address=18'd146944, SRAM_we_n=1, endF=0;
- pix_valid=0, pix_r/g/b=0, pix_eol=0, pix_last=0.
REQ-026 SHALL discard SRAM data returning after reset release for reads issued before reset.

Configuration
REQ-027 SHALL, with macro RGB_READER_CHECKSUM_EN defined, add output frame_sum (16 bits).
- Reset to 0; cleared on accepted startF.
- Adds pix_r+pix_g+pix_b modulo 2^16 on each transfer.
- Valid when endF=1.
REQ-028 SHALL, without RGB_READER_CHECKSUM_EN, have no frame_sum port and no checksum logic.

Structure
REQ-029 SHALL place the following in shared package m_pkg alongside existing milestone constants:
- RGB_BASE_ADDR=146944, IMG_WIDTH=320, IMG_HEIGHT=240, RGB_WORDS=115200;
- state enum RGB_RD_state.
REQ-030 SHALL implement the FIFO as sub-module word_fifo4: 16-bit, 4 entries, push/pop/count, simultaneous push and pop allowed.

Verification
REQ-031 SHALL verify, with a frame model and pix_ready=1: first pixel w0=16'h1122, w1=16'h3344, w2=16'h5566 -> pixel (11,22,33), then (44,55,66).
REQ-032 SHALL verify, with pix_ready=1 for a full frame: 76800 transfers; pix_eol on every 320th; pix_last only on the final one; endF rises the same cycle; 115200 reads issued.
REQ-033 SHALL verify, with pix_ready toggled randomly (30% high): no FIFO overflow, outputs stable while stalled, pixel sequence identical to REQ-032.
REQ-034 SHALL verify, with resetn pulsed low at word 5000: all outputs at reset values; a new startF restarts at address 146944 with first pixel matching REQ-031.
REQ-035 SHALL verify, with startF asserted during FETCH: no effect, address sequence uninterrupted.
REQ-036 SHALL verify, with RGB_READER_CHECKSUM_EN and all words 16'h0101: frame_sum = 76800*3 mod 65536 = 16'h8400.
